ins_fetch: RTL and testbench

//  Instruction source for ins_dec. Holds a 16-word program memory, loaded while idle, and a 4-bit PC.

---
 rtl/ins_pkg.sv | 33 +++
 rtl/prog_mem.sv | 27 ++
 rtl/ins_fetch.sv | 121 ++++++++++++
 tb/tb_ins_fetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_pkg.sv
// Shared instruction-format definitions for the fetch unit and ins_dec:
// widths, opcode values, field positions and the fetch state encoding.
package ins_pkg;

   localparam int INS_W = 11;
   localparam int PC_W  = 4;
   localparam int OP_W  = 3;

   // Field positions inside an instruction word.
   localparam int OP_MSB  = 10;
   localparam int OP_LSB  = 8;
   localparam int JMP_MSB = 7;
   localparam int JMP_LSB = 4;

   localparam logic [OP_W-1:0]  OP_BRANCH = 3'b100;
   localparam logic [OP_W-1:0]  OP_NOOP   = 3'b011;
   localparam logic [INS_W-1:0] NOOP_WORD = {OP_NOOP, 8'h00};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   function automatic logic [OP_W-1:0] ins_opcode(input logic [INS_W-1:0] ins);
      return ins[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [PC_W-1:0] ins_jmp(input logic [INS_W-1:0] ins);
      return ins[JMP_MSB:JMP_LSB];
   endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: register file with synchronous write and asynchronous read.
// Deliberately not reset so a loaded program survives rst_n.
module prog_mem #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 11
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: IDLE/RUN/HALT sequencer, PC, registered INS output and
// program memory. Taken branches are resolved from the word currently on INS.
module ins_fetch #(
   parameter int INS_W        = ins_pkg::INS_W,
   parameter int PC_W         = ins_pkg::PC_W,
   parameter int HALT_ON_WRAP = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             prog_we,
   input  logic [PC_W-1:0]  PROG_ADDR,
   input  logic [INS_W-1:0] PROG_DATA,
   input  logic             start,
   input  logic             stop,
   input  logic             branch_cond,
   output logic [INS_W-1:0] INS,
   output logic             ins_valid,
   output logic [PC_W-1:0]  PC,
   output logic             running
);

   import ins_pkg::*;

   fetch_state_e     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [INS_W-1:0] ins_q, ins_d;
   logic             ins_valid_q, ins_valid_d;

   logic [INS_W-1:0] mem_rd_data;
   logic             mem_we;
   logic             branch_taken;
   logic             wrap_halt;

   // The memory is only writable while idle, so a running program can't be
   // modified under its own feet.
   assign mem_we = prog_we && (state_q == IDLE);

   prog_mem #(
      .ADDR_W (PC_W),
      .DATA_W (INS_W)
   ) u_prog_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (PROG_ADDR),
      .wr_data (PROG_DATA),
      .rd_addr (pc_q),
      .rd_data (mem_rd_data)
   );

   // ins_valid gates the branch so an inserted NOOP can never be mistaken for one.
   assign branch_taken = (ins_q[OP_MSB:OP_LSB] == OP_BRANCH) && ins_valid_q && branch_cond;
   assign wrap_halt    = (HALT_ON_WRAP != 0) && (pc_q == {PC_W{1'b1}});

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ins_d       = ins_q;
      ins_valid_d = ins_valid_q;

      if (stop) begin
         state_d     = IDLE;
         pc_d        = '0;
         ins_d       = NOOP_WORD;
         ins_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE, HALT: begin
               pc_d        = '0;
               ins_d       = NOOP_WORD;
               ins_valid_d = 1'b0;
               if (start) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (branch_taken) begin
                  // Squash the sequential word already in flight.
                  pc_d        = ins_q[JMP_MSB:JMP_LSB];
                  ins_d       = NOOP_WORD;
                  ins_valid_d = 1'b0;
               end else begin
                  ins_d       = mem_rd_data;
                  ins_valid_d = 1'b1;
                  if (wrap_halt) begin
                     state_d = HALT;
                     pc_d    = '0;
                  end else begin
                     pc_d = pc_q + PC_W'(1);
                  end
               end
            end
            default: begin
               state_d     = IDLE;
               pc_d        = '0;
               ins_d       = NOOP_WORD;
               ins_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         ins_q       <= NOOP_WORD;
         ins_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ins_q       <= ins_d;
         ins_valid_q <= ins_valid_d;
      end
   end

   assign INS       = ins_q;
   assign ins_valid = ins_valid_q;
   assign PC        = pc_q;
   assign running   = (state_q == RUN);

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: two instances (wrap continues / wrap halts)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_ins_fetch;

   localparam logic [10:0] NOOP = 11'h300;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = 4'd0;
   logic [10:0] prog_data = 11'd0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        branch_cond = 1'b0;

   logic [10:0] ins0, ins1;
   logic        v0, v1;
   logic [3:0]  pc0, pc1;
   logic        run0, run1;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   ins_fetch #(.HALT_ON_WRAP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .PROG_ADDR(prog_addr),
      .PROG_DATA(prog_data), .start(start), .stop(stop), .branch_cond(branch_cond),
      .INS(ins0), .ins_valid(v0), .PC(pc0), .running(run0)
   );

   ins_fetch #(.HALT_ON_WRAP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .PROG_ADDR(prog_addr),
      .PROG_DATA(prog_data), .start(start), .stop(stop), .branch_cond(branch_cond),
      .INS(ins1), .ins_valid(v1), .PC(pc1), .running(run1)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 running, 2 halted. Index k selects the instance (k=1 halts on wrap).
   logic [10:0] m_mem [2][16];
   logic [10:0] m_ins [2] = '{NOOP, NOOP};
   bit          m_valid [2] = '{1'b0, 1'b0};
   int          m_pc [2] = '{0, 0};
   int          m_mode [2] = '{0, 0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_ins[k] = NOOP; m_valid[k] = 1'b0; m_pc[k] = 0; m_mode[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            bit we;
            logic [10:0] cur;
            we  = prog_we && (m_mode[k] == 0);
            cur = m_ins[k];
            if (stop) begin
               m_mode[k] = 0; m_pc[k] = 0; m_ins[k] = NOOP; m_valid[k] = 1'b0;
            end else if (m_mode[k] != 1) begin
               m_pc[k] = 0; m_ins[k] = NOOP; m_valid[k] = 1'b0;
               if (start) m_mode[k] = 1;
            end else if (cur[10:8] == 3'b100 && m_valid[k] && branch_cond) begin
               m_pc[k] = int'(cur[7:4]); m_ins[k] = NOOP; m_valid[k] = 1'b0;
            end else begin
               m_ins[k]   = m_mem[k][m_pc[k]];
               m_valid[k] = 1'b1;
               if (k == 1 && m_pc[k] == 15) begin
                  m_mode[k] = 2; m_pc[k] = 0;
               end else begin
                  m_pc[k] = (m_pc[k] + 1) % 16;
               end
            end
            if (we) m_mem[k][prog_addr] = prog_data;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         $display("t=%0t ins0=%h v0=%b pc0=%0d run0=%b | ins1=%h v1=%b pc1=%0d run1=%b",
                  $time, ins0, v0, pc0, run0, ins1, v1, pc1, run1);
         chk("ins0",  16'(ins0), 16'(m_ins[0]));
         chk("v0",    16'(v0),   16'(m_valid[0]));
         chk("pc0",   16'(pc0),  16'(m_pc[0]));
         chk("run0",  16'(run0), 16'(m_mode[0] == 1));
         chk("ins1",  16'(ins1), 16'(m_ins[1]));
         chk("v1",    16'(v1),   16'(m_valid[1]));
         chk("pc1",   16'(pc1),  16'(m_pc[1]));
         chk("run1",  16'(run1), 16'(m_mode[1] == 1));
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [10:0] fill(input int i);
      return {3'b010, 4'(i), 4'(i)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input int a, input logic [10:0] d);
      prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
      step();
      prog_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   initial begin
      step();
      step();
      rst_n  = 1'b1;
      cmp_on = 1'b1;
      chk("rst_ins", 16'(ins0), 16'(NOOP));
      chk("rst_valid", 16'(v0), 16'd0);
      chk("rst_pc", 16'(pc0), 16'd0);
      chk("rst_running", 16'(run0), 16'd0);

      for (int i = 0; i < 16; i++) write(i, fill(i));
      write(0, 11'h0A5);
      write(1, 11'h1F0);
      write(2, 11'h2C3);

      // Sequential fetch
      pulse_start();
      chk("t1_running", 16'(run0), 16'd1);
      step(); chk("t1_ins_a", 16'(ins0), 16'h0A5); chk("t1_pc_a", 16'(pc0), 16'd1);
      chk("t1_valid", 16'(v0), 16'd1);
      step(); chk("t1_ins_b", 16'(ins0), 16'h1F0); chk("t1_pc_b", 16'(pc0), 16'd2);
      step(); chk("t1_ins_c", 16'(ins0), 16'h2C3); chk("t1_pc_c", 16'(pc0), 16'd3);
      do_stop();
      chk("stop_ins", 16'(ins0), 16'(NOOP)); chk("stop_running", 16'(run0), 16'd0);
      chk("stop_pc", 16'(pc0), 16'd0);

      // Taken branch to 12
      write(1, 11'h4C0);
      branch_cond = 1'b1;
      pulse_start();
      step();
      step(); chk("t2_br_word", 16'(ins0), 16'h4C0); chk("t2_br_pc", 16'(pc0), 16'd2);
      step(); chk("t2_flush_ins", 16'(ins0), 16'(NOOP)); chk("t2_flush_v", 16'(v0), 16'd0);
      chk("t2_flush_pc", 16'(pc0), 16'd12);
      step(); chk("t2_tgt_ins", 16'(ins0), 16'h2CC); chk("t2_tgt_pc", 16'(pc0), 16'd13);
      branch_cond = 1'b0;
      do_stop();

      // Not-taken branch
      pulse_start();
      step();
      step(); chk("t3_br_word", 16'(ins0), 16'h4C0);
      step(); chk("t3_next_ins", 16'(ins0), 16'h2C3); chk("t3_next_pc", 16'(pc0), 16'd3);
      do_stop();
      write(1, 11'h1F0);

      // Wrap: instance 1 halts, instance 0 continues from 0
      pulse_start();
      repeat (16) step();
      chk("t4_last_ins1", 16'(ins1), 16'h2FF); chk("t4_halt_run1", 16'(run1), 16'd0);
      chk("t4_halt_pc1", 16'(pc1), 16'd0); chk("t4_run0", 16'(run0), 16'd1);
      step();
      chk("t4_halt_ins1", 16'(ins1), 16'(NOOP)); chk("t4_halt_v1", 16'(v1), 16'd0);
      chk("t4_wrap_ins0", 16'(ins0), 16'h0A5); chk("t4_wrap_pc0", 16'(pc0), 16'd1);
      pulse_start();
      chk("t4_restart_run1", 16'(run1), 16'd1); chk("t4_ignore_ins0", 16'(ins0), 16'h1F0);
      do_stop();

      // Writes in RUN are ignored; in IDLE they land
      pulse_start();
      prog_we = 1'b1; prog_addr = 4'd3; prog_data = 11'h7FF;
      step();
      prog_we = 1'b0;
      do_stop();
      pulse_start();
      repeat (4) step();
      chk("t5_mem3_kept", 16'(ins0), 16'h233);
      do_stop();
      write(3, 11'h7FF);
      pulse_start();
      repeat (4) step();
      chk("t5_mem3_new", 16'(ins0), 16'h7FF);
      do_stop();

      // start and stop together: stop wins
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk("ss_running", 16'(run0), 16'd0);

      // write and start in the same idle cycle
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = 11'h155; start = 1'b1;
      step();
      prog_we = 1'b0; start = 1'b0;
      step(); chk("ws_ins", 16'(ins0), 16'h155); chk("ws_pc", 16'(pc0), 16'd1);
      do_stop();

      // Branch to its own address: 2-cycle loop
      write(5, 11'h450);
      branch_cond = 1'b1;
      pulse_start();
      repeat (6) step();
      chk("loop_word", 16'(ins0), 16'h450); chk("loop_pc_a", 16'(pc0), 16'd6);
      step(); chk("loop_flush", 16'(ins0), 16'(NOOP)); chk("loop_pc_b", 16'(pc0), 16'd5);
      step(); chk("loop_again", 16'(ins0), 16'h450);
      branch_cond = 1'b0;
      step();

      // Asynchronous reset between edges
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_ins", 16'(ins0), 16'(NOOP)); chk("ar_pc", 16'(pc0), 16'd0);
      chk("ar_valid", 16'(v0), 16'd0); chk("ar_running", 16'(run0), 16'd0);
      step();
      rst_n = 1'b1;
      pulse_start();
      step(); chk("ar_refetch", 16'(ins0), 16'h155); chk("ar_refetch_pc", 16'(pc0), 16'd1);
      do_stop();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
